// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer controller.
//   - bus data width, prescaler/select widths
//   - register addresses, TCR bit positions, cks encodings
//   - load-sequencer state type
//   - cks_bit_idx(): maps a cks code to the prescaler bit it selects
package timer_pkg;

   localparam int TIMER_DATA_W    = 8;
   localparam int TIMER_CLK_SEL_W = 2;
   localparam int TIMER_PRESC_W   = 4;

   localparam logic [7:0] ADDR_TDR = 8'h00;
   localparam logic [7:0] ADDR_TCR = 8'h01;
   localparam logic [7:0] ADDR_TSR = 8'h02;
   localparam logic [7:0] ADDR_TIE = 8'h03;

   localparam int TCR_LOAD_BIT = 7;
   localparam int TCR_UPDN_BIT = 5;
   localparam int TCR_EN_BIT   = 4;

   localparam logic [TIMER_CLK_SEL_W-1:0] CKS_DIV2  = 2'b00;
   localparam logic [TIMER_CLK_SEL_W-1:0] CKS_DIV4  = 2'b01;
   localparam logic [TIMER_CLK_SEL_W-1:0] CKS_DIV8  = 2'b10;
   localparam logic [TIMER_CLK_SEL_W-1:0] CKS_DIV16 = 2'b11;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_ARMED   = 2'd1,
      SEQ_LOADING = 2'd2
   } seq_state_t;

   function automatic int cks_bit_idx(input logic [TIMER_CLK_SEL_W-1:0] cks);
      case (cks)
         CKS_DIV2:  return 0;
         CKS_DIV4:  return 1;
         CKS_DIV8:  return 2;
         CKS_DIV16: return 3;
         default:   return 0;
      endcase
   endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: APB-style register bus between system and timer_ctrl.
//   master: psel/penable/pwrite/paddr/pwdata out, prdata/pready/pslverr in
//   slave : mirror of master
interface timer_ctrl_if;
   import timer_pkg::*;

   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [7:0]              paddr;
   logic [TIMER_DATA_W-1:0] pwdata;
   logic [TIMER_DATA_W-1:0] prdata;
   logic                    pready;
   logic                    pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider producing the counter's clk_ena.
//   clk, rst   : clock, async active-high reset
//   i_cks      : divider select (bit 0..3 of the divider counter)
//   i_switch   : one-cycle strobe on the edge where cks changes
//   o_clk_ena  : registered one-cycle pulse on each rising edge of the
//                selected divider bit
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PRESC_W   = TIMER_PRESC_W,
   parameter int CLK_SEL_W = TIMER_CLK_SEL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CLK_SEL_W-1:0] i_cks,
   input  logic                 i_switch,
   output logic                 o_clk_ena
);

   logic [PRESC_W-1:0] r_cnt;
   logic               r_sel;
   logic               r_sel_d1;
   logic               r_blank;
   logic               r_clk_ena;

   logic [PRESC_W-1:0] w_cnt_prev;
   int                 w_idx;
   logic               w_sel;
   logic               w_sel_prev;

   always_comb begin
      w_cnt_prev = r_cnt - 1'b1;
      w_idx      = cks_bit_idx(i_cks);
      w_sel      = r_cnt[w_idx];
      w_sel_prev = w_cnt_prev[w_idx];
   end

   // During the blank cycle after a select switch, the delayed bit is
   // rebuilt from the previous count under the new select, so the first
   // unblanked edge compares two samples of the same divider bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_sel     <= 1'b0;
         r_sel_d1  <= 1'b0;
         r_blank   <= 1'b0;
         r_clk_ena <= 1'b0;
      end else begin
         r_cnt     <= r_cnt + 1'b1;
         r_sel     <= w_sel;
         r_sel_d1  <= r_blank ? w_sel_prev : r_sel;
         r_blank   <= i_switch;
         r_clk_ena <= r_sel & ~r_sel_d1 & ~i_switch & ~r_blank;
      end
   end

   assign o_clk_ena = r_clk_ena;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: register file, prescaler and load sequencer for one counter.
//   clk, rst          : clock, async active-high reset
//   apb               : register bus (slave), zero wait state
//   i_overflow/i_underflow : counter status
//   o_start_counter   : TDR value
//   o_load/o_up_down/o_enable : counter controls
//   o_clk_ena         : count-enable pulse from the prescaler
//   o_clr_overflow/o_clr_underflow : one-cycle W1C strobes
//   o_irq             : registered interrupt
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_SEL_W = TIMER_CLK_SEL_W,
   parameter int PRESC_W   = TIMER_PRESC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   timer_ctrl_if.slave             apb,
   input  logic                    i_overflow,
   input  logic                    i_underflow,
   output logic [TIMER_DATA_W-1:0] o_start_counter,
   output logic                    o_load,
   output logic                    o_up_down,
   output logic                    o_enable,
   output logic                    o_clk_ena,
   output logic                    o_clr_overflow,
   output logic                    o_clr_underflow,
   output logic                    o_irq
);

   logic [TIMER_DATA_W-1:0] r_tdr;
   logic                    r_up;
   logic                    r_en;
   logic [CLK_SEL_W-1:0]    r_cks;
   logic [1:0]              r_tie;
   logic                    r_clr_ovf;
   logic                    r_clr_udf;
   logic                    r_irq;
   seq_state_t              r_state;

   seq_state_t              w_state_nxt;
   logic                    w_load;
   logic                    w_access;
   logic                    w_wr;
   logic                    w_wr_tcr;
   logic                    w_load_req;
   logic                    w_switch;
   logic                    w_clk_ena;
   logic [TIMER_DATA_W-1:0] w_tcr;
   logic [TIMER_DATA_W-1:0] w_rdata;

   assign w_access   = apb.psel & apb.penable;
   assign w_wr       = w_access & apb.pwrite;
   assign w_wr_tcr   = w_wr & (apb.paddr == ADDR_TCR);
   assign w_load_req = w_wr_tcr & apb.pwdata[TCR_LOAD_BIT];
   // Blank only on an actual select change; rewriting the same cks
   // (e.g. a load request) leaves the pulse train untouched.
   assign w_switch   = w_wr_tcr & (apb.pwdata[CLK_SEL_W-1:0] != r_cks);

   timer_prescaler #(
      .PRESC_W   (PRESC_W),
      .CLK_SEL_W (CLK_SEL_W)
   ) u_presc (
      .clk       (clk),
      .rst       (rst),
      .i_cks     (r_cks),
      .i_switch  (w_switch),
      .o_clk_ena (w_clk_ena)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tdr     <= '0;
         r_up      <= 1'b0;
         r_en      <= 1'b0;
         r_cks     <= CKS_DIV2;
         r_tie     <= '0;
         r_clr_ovf <= 1'b0;
         r_clr_udf <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_clr_ovf <= w_wr & (apb.paddr == ADDR_TSR) & apb.pwdata[0];
         r_clr_udf <= w_wr & (apb.paddr == ADDR_TSR) & apb.pwdata[1];
         r_irq     <= (i_overflow & r_tie[0]) | (i_underflow & r_tie[1]);
         if (w_wr) begin
            case (apb.paddr)
               ADDR_TDR: r_tdr <= apb.pwdata;
               ADDR_TCR: begin
                  r_up  <= apb.pwdata[TCR_UPDN_BIT];
                  r_en  <= apb.pwdata[TCR_EN_BIT];
                  r_cks <= apb.pwdata[CLK_SEL_W-1:0];
               end
               ADDR_TIE: r_tie <= apb.pwdata[1:0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= SEQ_IDLE;
      else     r_state <= w_state_nxt;
   end

   // A fresh load request always re-arms, stretching load to a full
   // clk_ena period from the latest request.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            if (w_load_req) w_state_nxt = SEQ_ARMED;
         end
         SEQ_ARMED: begin
            w_load = 1'b1;
            if (w_load_req)     w_state_nxt = SEQ_ARMED;
            else if (w_clk_ena) w_state_nxt = SEQ_LOADING;
         end
         SEQ_LOADING: begin
            w_load      = 1'b1;
            w_state_nxt = w_load_req ? SEQ_ARMED : SEQ_IDLE;
         end
         default: w_state_nxt = SEQ_IDLE;
      endcase
   end

   always_comb begin
      w_tcr                  = '0;
      w_tcr[TCR_LOAD_BIT]    = w_load;
      w_tcr[TCR_UPDN_BIT]    = r_up;
      w_tcr[TCR_EN_BIT]      = r_en;
      w_tcr[CLK_SEL_W-1:0]   = r_cks;
      w_rdata                = '0;
      case (apb.paddr)
         ADDR_TDR: w_rdata = r_tdr;
         ADDR_TCR: w_rdata = w_tcr;
         ADDR_TSR: w_rdata = {6'b0, i_underflow, i_overflow};
         ADDR_TIE: w_rdata = {6'b0, r_tie};
         default:  w_rdata = '0;
      endcase
   end

   assign apb.prdata  = w_access ? w_rdata : '0;
   assign apb.pready  = w_access;
   assign apb.pslverr = w_access & (apb.paddr > ADDR_TIE);

   assign o_start_counter = r_tdr;
   assign o_load          = w_load;
   assign o_up_down       = r_up;
   assign o_enable        = r_en;
   assign o_clk_ena       = w_clk_ena;
   assign o_clr_overflow  = r_clr_ovf;
   assign o_clr_underflow = r_clr_udf;
   assign o_irq           = r_irq;

endmodule
